// File: rtl/breath_pkg.sv
// rtl/breath_pkg.sv - shared state encoding and default timing for the breathing ramp sequencer
package breath_pkg;

    localparam int PHASE_W = 3;
    localparam int FRAME_W = 16;

    typedef enum logic [PHASE_W-1:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HIGH = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LOW  = 3'd4
    } state_t;

    localparam int DEF_DUTY_W          = 19;
    localparam int DEF_PWM_CYCLE       = 500000;
    localparam int DEF_DUTY_MIN        = 25000;
    localparam int DEF_DUTY_MAX        = 475000;
    localparam int DEF_STEP            = 50000;
    localparam int DEF_FRAMES_PER_STEP = 15;
    localparam int DEF_HOLD_FRAMES     = 50;

endpackage

// File: rtl/frame_div.sv
// rtl/frame_div.sv - PWM-period counter with a runtime terminal count
module frame_div
    import breath_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               clr,
    input  logic [FRAME_W-1:0] tc_val,
    output logic               tc
);

    logic [FRAME_W-1:0] cnt_q;
    logic [FRAME_W-1:0] cnt_d;

    // tc fires on the period_end that completes the current span
    assign tc = inc && (cnt_q == tc_val);

    // clear wins over counting; wrap to zero on terminal count
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tc) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + FRAME_W'(1);
        end
    end

    // counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/breath_ramp_ctrl.sv
// rtl/breath_ramp_ctrl.sv - duty schedule sequencer for a breathing LED PWM generator
module breath_ramp_ctrl
    import breath_pkg::*;
#(
    parameter int DUTY_W          = DEF_DUTY_W,
    parameter int PWM_CYCLE       = DEF_PWM_CYCLE,
    parameter int DUTY_MIN        = DEF_DUTY_MIN,
    parameter int DUTY_MAX        = DEF_DUTY_MAX,
    parameter int STEP            = DEF_STEP,
    parameter int FRAMES_PER_STEP = DEF_FRAMES_PER_STEP,
    parameter int HOLD_FRAMES     = DEF_HOLD_FRAMES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               abort,
    input  logic [7:0]         n_breaths,
    input  logic               period_end,
    output logic [DUTY_W-1:0]  duty,
    output logic               duty_vld,
    output logic [PHASE_W-1:0] phase,
    output logic               busy,
    output logic               done
);

    if (DUTY_MAX > PWM_CYCLE) begin : g_bad_cycle
        $error("DUTY_MAX exceeds PWM_CYCLE");
    end
    if (DUTY_MIN > DUTY_MAX) begin : g_bad_range
        $error("DUTY_MIN exceeds DUTY_MAX");
    end
    if (STEP <= 0 || FRAMES_PER_STEP < 1) begin : g_bad_step
        $error("STEP and FRAMES_PER_STEP must be positive");
    end

    localparam logic [DUTY_W-1:0]  MIN_D   = DUTY_W'(DUTY_MIN);
    localparam logic [DUTY_W-1:0]  MAX_D   = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W:0]    STEP_X  = (DUTY_W+1)'(STEP);
    localparam logic [DUTY_W:0]    MAX_X   = (DUTY_W+1)'(DUTY_MAX);
    localparam logic [DUTY_W:0]    DN_TH_X = (DUTY_W+1)'(DUTY_MIN + STEP);
    localparam logic [DUTY_W-1:0]  STEP_D  = DUTY_W'(STEP);
    localparam bit                 FLAT    = (DUTY_MIN == DUTY_MAX);
    localparam logic [FRAME_W-1:0] RAMP_TC = FRAME_W'(FRAMES_PER_STEP - 1);
    localparam logic [FRAME_W-1:0] HOLD_TC = (HOLD_FRAMES == 0) ? '0 : FRAME_W'(HOLD_FRAMES - 1);

    state_t             state_q, state_d, exit_state;
    logic [DUTY_W-1:0]  duty_q, duty_d, up_val, dn_val;
    logic [DUTY_W:0]    up_sum;
    logic               duty_vld_q, duty_vld_d;
    logic               done_q, done_d;
    logic [7:0]         breath_q, breath_d, breath_inc;
    logic [7:0]         nlat_q, nlat_d;
    logic               stop_pend_q, stop_pend_d;
    logic               exit_idle;
    logic               frame_inc, frame_clr, frame_tc;
    logic [FRAME_W-1:0] tc_val;

    // frames only count while a sequence runs; any state change restarts the span
    assign frame_inc = period_end && (state_q != IDLE);
    assign frame_clr = (state_d != state_q);
    assign tc_val    = (state_q == HOLD_HIGH || state_q == HOLD_LOW) ? HOLD_TC : RAMP_TC;

    frame_div u_frame_div (
        .clk    (clk),
        .rst    (rst),
        .inc    (frame_inc),
        .clr    (frame_clr),
        .tc_val (tc_val),
        .tc     (frame_tc)
    );

    // saturating step arithmetic and the decision taken when HOLD_LOW ends
    always_comb begin
        up_sum     = {1'b0, duty_q} + STEP_X;
        up_val     = (up_sum >= MAX_X) ? MAX_D : up_sum[DUTY_W-1:0];
        dn_val     = ({1'b0, duty_q} >= DN_TH_X) ? (duty_q - STEP_D) : MIN_D;
        breath_inc = breath_q + 8'd1;
        exit_idle  = stop_pend_q || stop || ((nlat_q != 8'd0) && (breath_inc == nlat_q));
        exit_state = exit_idle ? IDLE : (FLAT ? HOLD_HIGH : RAMP_UP);
    end

    // next-state, duty schedule and bookkeeping; abort overrides everything
    always_comb begin
        state_d     = state_q;
        duty_d      = duty_q;
        done_d      = 1'b0;
        breath_d    = breath_q;
        nlat_d      = nlat_q;
        stop_pend_d = stop_pend_q;
        if (stop && state_q != IDLE) begin
            stop_pend_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = FLAT ? HOLD_HIGH : RAMP_UP;
                    duty_d   = MIN_D;
                    breath_d = 8'd0;
                    nlat_d   = n_breaths;
                end
            end
            RAMP_UP: begin
                if (frame_tc) begin
                    duty_d = up_val;
                    if (up_val == MAX_D) begin
                        state_d = (HOLD_FRAMES == 0) ? RAMP_DOWN : HOLD_HIGH;
                    end
                end
            end
            HOLD_HIGH: begin
                if (frame_tc) begin
                    state_d = FLAT ? HOLD_LOW : RAMP_DOWN;
                end
            end
            RAMP_DOWN: begin
                if (frame_tc) begin
                    duty_d = dn_val;
                    if (dn_val == MIN_D) begin
                        if (HOLD_FRAMES != 0) begin
                            state_d = HOLD_LOW;
                        end else begin
                            state_d  = exit_state;
                            breath_d = breath_inc;
                            if (exit_idle) begin
                                duty_d = '0;
                                done_d = 1'b1;
                            end
                        end
                    end
                end
            end
            HOLD_LOW: begin
                if (frame_tc) begin
                    state_d  = exit_state;
                    breath_d = breath_inc;
                    if (exit_idle) begin
                        duty_d = '0;
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                duty_d  = '0;
            end
        endcase
        if (abort) begin
            state_d  = IDLE;
            duty_d   = '0;
            done_d   = 1'b0;
            breath_d = 8'd0;
            nlat_d   = 8'd0;
        end
        if (state_d == IDLE) begin
            stop_pend_d = 1'b0;
        end
        duty_vld_d = (duty_d != duty_q);
    end

    // state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            duty_q      <= '0;
            duty_vld_q  <= 1'b0;
            done_q      <= 1'b0;
            breath_q    <= 8'd0;
            nlat_q      <= 8'd0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            duty_vld_q  <= duty_vld_d;
            done_q      <= done_d;
            breath_q    <= breath_d;
            nlat_q      <= nlat_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    // outputs decoded from the registered state
    always_comb begin
        phase    = state_q;
        busy     = (state_q != IDLE);
        duty     = duty_q;
        duty_vld = duty_vld_q;
        done     = done_q;
    end

endmodule

// File: tb/tb_breath_ramp_ctrl.sv
// tb/tb_breath_ramp_ctrl.sv - scoreboard bench for breath_ramp_ctrl
module tb_breath_ramp_ctrl;
    import breath_pkg::*;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_a = 1'b0, stop_a = 1'b0, abort_a = 1'b0;
    logic          start_b = 1'b0, stop_b = 1'b0, abort_b = 1'b0;
    logic          period_end = 1'b0;
    logic [7:0]    nb_a = 8'd0, nb_b = 8'd0;
    logic [DW-1:0] duty_a, duty_b;
    logic          vld_a, vld_b, busy_a, busy_b, done_a, done_b;
    logic [2:0]    phase_a, phase_b, prev_ph;

    int checks = 0;
    int errors = 0;
    int pe_cnt = 0;
    int pe_seen, ups, found;

    typedef struct {
        logic [7:0] duty;
        logic       done;
        logic       pe;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    logic pe_prev_a, pe_prev_b;

    breath_ramp_ctrl #(
        .DUTY_W(DW), .PWM_CYCLE(100), .DUTY_MIN(10), .DUTY_MAX(50),
        .STEP(20), .FRAMES_PER_STEP(2), .HOLD_FRAMES(3)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .abort(abort_a),
        .n_breaths(nb_a), .period_end(period_end), .duty(duty_a), .duty_vld(vld_a),
        .phase(phase_a), .busy(busy_a), .done(done_a)
    );

    breath_ramp_ctrl #(
        .DUTY_W(DW), .PWM_CYCLE(100), .DUTY_MIN(10), .DUTY_MAX(50),
        .STEP(15), .FRAMES_PER_STEP(2), .HOLD_FRAMES(3)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .abort(abort_b),
        .n_breaths(nb_b), .period_end(period_end), .duty(duty_b), .duty_vld(vld_b),
        .phase(phase_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_a(input logic [7:0] d, input logic dn, input logic p);
        exp_t e;
        e.duty = d; e.done = dn; e.pe = p;
        q_a.push_back(e);
    endtask

    task automatic push_b(input logic [7:0] d, input logic dn, input logic p);
        exp_t e;
        e.duty = d; e.done = dn; e.pe = p;
        q_b.push_back(e);
    endtask

    task automatic push_breath_a();
        push_a(8'd30, 1'b0, 1'b1);
        push_a(8'd50, 1'b0, 1'b1);
        push_a(8'd30, 1'b0, 1'b1);
        push_a(8'd10, 1'b0, 1'b1);
    endtask

    // one cycle: drive at the falling edge, pulses default low, period_end every 100 clocks
    task automatic cyc();
        @(negedge clk);
        pe_cnt     = (pe_cnt == 99) ? 0 : pe_cnt + 1;
        period_end = (pe_cnt == 99);
        start_a    = 1'b0;
        stop_a     = 1'b0;
        abort_a    = 1'b0;
        start_b    = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while ((busy_a || busy_b) && n < budget);
        check(name, int'(busy_a || busy_b), 0);
    endtask

    // monitor A: every duty_vld pops one expected update
    always @(posedge clk) begin
        pe_prev_a = period_end;
        #1;
        if (vld_a) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL sb_a_extra: duty_vld with duty %0d, none expected", duty_a);
            end else begin
                ea = q_a.pop_front();
                if (duty_a !== ea.duty || done_a !== ea.done || (ea.pe && !pe_prev_a)) begin
                    errors++;
                    $display("FAIL sb_a: duty %0d done %0b pe %0b, expected duty %0d done %0b pe %0b",
                             duty_a, done_a, pe_prev_a, ea.duty, ea.done, ea.pe);
                end
            end
        end else if (done_a) begin
            checks++;
            errors++;
            $display("FAIL sb_a_done: done %0b without duty_vld, expected 0", done_a);
        end
    end

    // monitor B: same discipline for the STEP=15 instance
    always @(posedge clk) begin
        pe_prev_b = period_end;
        #1;
        if (vld_b) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL sb_b_extra: duty_vld with duty %0d, none expected", duty_b);
            end else begin
                eb = q_b.pop_front();
                if (duty_b !== eb.duty || done_b !== eb.done || (eb.pe && !pe_prev_b)) begin
                    errors++;
                    $display("FAIL sb_b: duty %0d done %0b pe %0b, expected duty %0d done %0b pe %0b",
                             duty_b, done_b, pe_prev_b, eb.duty, eb.done, eb.pe);
                end
            end
        end else if (done_b) begin
            checks++;
            errors++;
            $display("FAIL sb_b_done: done %0b without duty_vld, expected 0", done_b);
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_duty", int'(duty_a), 0);
        check("rst_vld", int'(vld_a), 0);
        check("rst_phase", int'(phase_a), int'(IDLE));
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);

        // single breath on both instances: STEP=20 and saturating STEP=15
        cyc();
        start_a = 1'b1; nb_a = 8'd1;
        start_b = 1'b1; nb_b = 8'd1;
        push_a(8'd10, 1'b0, 1'b0);
        push_breath_a();
        push_a(8'd0, 1'b1, 1'b1);
        push_b(8'd10, 1'b0, 1'b0);
        push_b(8'd25, 1'b0, 1'b1);
        push_b(8'd40, 1'b0, 1'b1);
        push_b(8'd50, 1'b0, 1'b1);
        push_b(8'd35, 1'b0, 1'b1);
        push_b(8'd20, 1'b0, 1'b1);
        push_b(8'd10, 1'b0, 1'b1);
        push_b(8'd0, 1'b1, 1'b1);
        wait_idle(2500, "t1_idle_timeout");
        check("t1_duty_end", int'(duty_a), 0);
        check("t1_sb_a_left", q_a.size(), 0);
        check("t1_sb_b_left", q_b.size(), 0);

        // start coincident with period_end, then a second start while busy
        cyc();
        start_a = 1'b1; nb_a = 8'd1; period_end = 1'b1;
        push_a(8'd10, 1'b0, 1'b0);
        push_breath_a();
        push_a(8'd0, 1'b1, 1'b1);
        pe_seen = 0;
        for (int i = 0; i < 400; i++) begin
            cyc();
            if (vld_a && duty_a == 8'd30) break;
            if (i == 20) begin
                start_a = 1'b1;
                nb_a    = 8'd5;
            end
            if (period_end) pe_seen++;
        end
        check("t5_pe_before_first_step", pe_seen, 2);
        check("t5_phase_ramp_up", int'(phase_a), int'(RAMP_UP));
        wait_idle(2000, "t5_idle_timeout");
        check("t5_sb_a_left", q_a.size(), 0);

        // infinite run, stop in the third breath's RAMP_UP
        cyc();
        start_a = 1'b1; nb_a = 8'd0;
        push_a(8'd10, 1'b0, 1'b0);
        repeat (3) push_breath_a();
        push_a(8'd0, 1'b1, 1'b1);
        ups = 0;
        prev_ph = phase_a;
        for (int i = 0; i < 5000 && ups < 2; i++) begin
            cyc();
            if (prev_ph == 3'(HOLD_LOW) && phase_a == 3'(RAMP_UP)) ups++;
            prev_ph = phase_a;
        end
        repeat (150) cyc();
        check("t3_phase_before_stop", int'(phase_a), int'(RAMP_UP));
        stop_a = 1'b1;
        cyc();
        stop_a = 1'b1;
        wait_idle(2000, "t3_idle_timeout");
        check("t3_sb_a_left", q_a.size(), 0);

        // start together with abort stays idle
        cyc();
        start_a = 1'b1; abort_a = 1'b1;
        cyc();
        cyc();
        check("t4_start_abort_phase", int'(phase_a), int'(IDLE));
        check("t4_start_abort_busy", int'(busy_a), 0);

        // abort one cycle after the duty=50 update, with a period_end alongside
        cyc();
        start_a = 1'b1; nb_a = 8'd0;
        push_a(8'd10, 1'b0, 1'b0);
        push_a(8'd30, 1'b0, 1'b1);
        push_a(8'd50, 1'b0, 1'b1);
        push_a(8'd0, 1'b0, 1'b0);
        found = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc();
            if (vld_a && duty_a == 8'd50) begin
                found = 1;
                break;
            end
        end
        check("t4_reached_max", found, 1);
        abort_a = 1'b1; period_end = 1'b1;
        cyc();
        check("t4_abort_phase", int'(phase_a), int'(IDLE));
        check("t4_abort_duty", int'(duty_a), 0);
        check("t4_abort_vld", int'(vld_a), 1);
        check("t4_abort_done", int'(done_a), 0);
        check("t4_abort_busy", int'(busy_a), 0);
        cyc();
        check("t4_after_vld", int'(vld_a), 0);
        check("t4_after_phase", int'(phase_a), int'(IDLE));

        // asynchronous reset in the middle of RAMP_DOWN
        cyc();
        start_a = 1'b1; nb_a = 8'd1;
        push_a(8'd10, 1'b0, 1'b0);
        push_a(8'd30, 1'b0, 1'b1);
        push_a(8'd50, 1'b0, 1'b1);
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            cyc();
            if (phase_a == 3'(RAMP_DOWN)) begin
                found = 1;
                break;
            end
        end
        check("t6_reached_ramp_down", found, 1);
        #3 rst = 1'b1;
        #1;
        check("t6_rst_duty", int'(duty_a), 0);
        check("t6_rst_vld", int'(vld_a), 0);
        check("t6_rst_phase", int'(phase_a), int'(IDLE));
        check("t6_rst_busy", int'(busy_a), 0);
        check("t6_rst_done", int'(done_a), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (300) cyc();
        check("t6_post_phase", int'(phase_a), int'(IDLE));
        check("t6_post_busy", int'(busy_a), 0);
        check("t6_post_duty", int'(duty_a), 0);

        repeat (5) cyc();
        check("end_sb_a_left", q_a.size(), 0);
        check("end_sb_b_left", q_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/breath_ramp_ctrl.md
Name: breath_ramp_ctrl

Overview:
- Sequencer that drives the duty value of a downstream PWM generator to produce a breathing LED.
- Ramps duty up, holds, ramps down, holds, and repeats for a programmed number of breaths (or forever).
- Duty changes only on PWM period boundaries, which the generator signals via period_end, so no period is glitched.
- The generator owns the period counter and the LED polarity; this block owns only the duty schedule.

Parameters:
- DUTY_W, 19: width of duty and of the generator's period counter.
- PWM_CYCLE, 500000: clocks per PWM period. Checked only: DUTY_MAX <= PWM_CYCLE.
- DUTY_MIN, 25000: floor of the ramp, in on-clocks per period.
- DUTY_MAX, 475000: ceiling of the ramp. Requires DUTY_MIN <= DUTY_MAX.
- STEP, 50000: duty increment/decrement per step. Must be > 0.
- FRAMES_PER_STEP, 15: PWM periods between steps. Must be >= 1.
- HOLD_FRAMES, 50: PWM periods spent at max and at min. 0 = no hold.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a sequence when idle
- stop  in  1  one-cycle pulse; graceful stop at the end of the current HOLD_LOW
- abort  in  1  level or pulse; immediate return to idle
- n_breaths  in  8  number of breaths, sampled at start; 0 = infinite
- period_end  in  1  one-cycle pulse from the generator on the last clock of each PWM period
- duty  out  DUTY_W  on-time in clocks for the generator, registered
- duty_vld  out  1  one-cycle pulse, same cycle duty takes a new value
- phase  out  3  current FSM state encoding
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a finite sequence or a graceful stop completes

Behaviour:
- Reset values: duty=0, duty_vld=0, phase=IDLE, busy=0, done=0. Internal frame counter, breath counter, stop_pend and n_breaths latch are all 0.
- States: IDLE, RAMP_UP, HOLD_HIGH, RAMP_DOWN, HOLD_LOW.
- IDLE + start (abort low):
  - next cycle: duty=DUTY_MIN, duty_vld=1, phase=RAMP_UP, busy=1.
  - frame counter and breath counter cleared; n_breaths latched.
- Frame counter:
  - increments only on period_end while busy.
  - terminal count is FRAMES_PER_STEP-1 in ramp states and HOLD_FRAMES-1 in hold states.
  - clears on terminal count and on every state change.
- RAMP_UP at terminal count: duty = min(duty+STEP, DUTY_MAX), sum computed DUTY_W+1 bits wide. If the result equals DUTY_MAX, go to HOLD_HIGH, or straight to RAMP_DOWN if HOLD_FRAMES=0.
- RAMP_DOWN at terminal count: duty = max(duty-STEP, DUTY_MIN), underflow-safe compare before subtracting. If the result equals DUTY_MIN, go to HOLD_LOW, or straight to the HOLD_LOW exit logic if HOLD_FRAMES=0.
- HOLD_HIGH at terminal count: go to RAMP_DOWN; duty unchanged; no duty_vld.
- HOLD_LOW exit:
  - breath counter increments.
  - if stop_pend, or n_breaths!=0 and new count==n_breaths: go to IDLE, duty=0, duty_vld=1, done=1, busy=0 next cycle.
  - else go to RAMP_UP, first step on the next terminal count.
- Latency: period_end at cycle N produces the duty/duty_vld update at N+1. duty_vld only pulses when duty actually changes value.
- DUTY_MIN==DUTY_MAX: ramps are skipped, alternating holds only, no duty_vld after start.
- stop:
  - sets stop_pend while busy; ignored in IDLE.
  - a second stop is a no-op; stop_pend clears on entry to IDLE.
- abort: wins over every other event. Next cycle: IDLE, duty=0, duty_vld=1 if duty was nonzero, done=0, all counters and stop_pend cleared.
- start while busy: ignored. start and abort in the same cycle: stays IDLE.
- period_end in IDLE: ignored. start and period_end in the same cycle: the period_end is not counted.
- Breath counter is 8 bits. With n_breaths=0 it wraps freely with no effect.

Decomposition:
- Package breath_pkg: state encoding localparams (IDLE=0, RAMP_UP=1, HOLD_HIGH=2, RAMP_DOWN=3, HOLD_LOW=4), default timing constants, PHASE_W=3.
- One sub-module, frame_div: counter with inc, clr and a runtime terminal-count input; outputs tc. The FSM, saturating duty arithmetic and breath counter stay in breath_ramp_ctrl.

Test Plan (parameters: PWM_CYCLE=100, DUTY_W=8, DUTY_MIN=10, DUTY_MAX=50, STEP=20, FRAMES_PER_STEP=2, HOLD_FRAMES=3; period_end every 100 clocks):
- start, n_breaths=1 -> duty 10,30,50 (updates every 2 period_ends), 3-period hold, then 30,10, 3-period hold; then duty=0, done pulse, busy=0. Exactly 5 duty_vld pulses after start, plus 1 at the end.
- STEP=15 -> up sequence 10,25,40,50 with saturation at 50; down sequence 50,35,20,10 with floor at 10. Never exceeds the bounds.
- n_breaths=0 running 3 breaths, stop pulse mid RAMP_UP -> continues through a full RAMP_DOWN and HOLD_LOW, then IDLE with done=1.
- abort one cycle after the duty=50 update -> next cycle duty=0, duty_vld=1, phase=IDLE, done=0. A period_end the same cycle is ignored.
- start asserted with period_end in the same cycle, then a second start while busy -> first step lands after 2 further period_ends; second start has no effect.
- Assert rst mid RAMP_DOWN (asynchronously, between clock edges) -> all outputs go to reset values immediately. After release, stays IDLE until the next start.
